// File: rtl/fan_aim_ctrl.sv
// fan_aim_ctrl -- sequencing controller for the fan-direction servo.
// Accepts aim commands (PARK/SWEEP/HOLD/GOTO) and music beats, schedules
// rate-limited position updates, and generates the servo PWM frame with
// frame-aligned width updates.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick_us         1 MHz enable, advances PWM frame counter
//   tick_step       5 Hz enable, advances servo position
//   cmd_valid/ready command handshake; cmd_op, cmd_arg command payload
//   beat            one-clk music beat pulse (reverses sweep direction)
//   pwm_out         registered servo PWM
//   pos             current commanded pulse width (us)
//   state           0=HOLD, 1=SWEEP, 2=MOVE
//   busy            high while in MOVE
module fan_aim_ctrl #(
  parameter int PERIOD_US = 20000,
  parameter int POS_MIN   = 1000,
  parameter int POS_MAX   = 2000,
  parameter int POS_PARK  = 1500,
  parameter int STEP      = 35,
  parameter int GOTO_GAIN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_us,
  input  logic        tick_step,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_arg,
  output logic        cmd_ready,
  input  logic        beat,
  output logic        pwm_out,
  output logic [10:0] pos,
  output logic [1:0]  state,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_MOVE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_PARK  = 2'd0;
  localparam logic [1:0] OP_SWEEP = 2'd1;
  localparam logic [1:0] OP_HOLD  = 2'd2;
  localparam logic [1:0] OP_GOTO  = 2'd3;

  localparam logic [10:0] MIN_W  = 11'(POS_MIN);
  localparam logic [10:0] MAX_W  = 11'(POS_MAX);
  localparam logic [10:0] PARK_W = 11'(POS_PARK);
  localparam logic [14:0] LAST_CNT = 15'(PERIOD_US - 1);

  // Saturating upward step; the sum is formed in 12 bits so it never wraps.
  function automatic logic [10:0] sat_up(input logic [10:0] p);
    logic [11:0] s;
    s = {1'b0, p} + 12'(STEP);
    if (s >= 12'(POS_MAX)) return MAX_W;
    return s[10:0];
  endfunction

  // Saturating downward step in signed 12 bits.
  function automatic logic [10:0] sat_down(input logic [10:0] p);
    logic signed [11:0] s;
    s = signed'({1'b0, p}) - 12'sd35 + 12'sd35 - 12'(STEP);
    if (s <= signed'(12'(POS_MIN))) return MIN_W;
    return s[10:0];
  endfunction

  // Rate-limited move toward the target: at most STEP per call.
  function automatic logic [10:0] move_toward(input logic [10:0] p,
                                              input logic [10:0] t);
    logic [10:0] d;
    if (p < t) begin
      d = t - p;
      return (d > 11'(STEP)) ? p + 11'(STEP) : t;
    end
    d = p - t;
    return (d > 11'(STEP)) ? p - 11'(STEP) : t;
  endfunction

  // GOTO target: computed in 12 bits, clamped, then narrowed to 11 bits.
  function automatic logic [10:0] goto_target(input logic [3:0] arg);
    logic [11:0] t;
    t = 12'(POS_MIN) + 12'(arg) * 12'(GOTO_GAIN);
    if (t > 12'(POS_MAX)) t = 12'(POS_MAX);
    return t[10:0];
  endfunction

  state_t      state_q, state_d;
  logic [10:0] pos_q, pos_d;
  logic [10:0] target_q, target_d;
  logic        dir_q, dir_d;          // 1 = up
  logic [14:0] cnt_q, cnt_d;
  logic [10:0] width_q, width_d;
  logic        pwm_q;

  logic        accept;
  logic        dir_eff;
  logic [10:0] nxt;

  assign busy      = (state_q == ST_MOVE);
  assign cmd_ready = ~busy;
  assign accept    = cmd_valid & cmd_ready;
  assign pos       = pos_q;
  assign state     = state_q;
  assign pwm_out   = pwm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HOLD;
      pos_q    <= PARK_W;
      target_q <= PARK_W;
      dir_q    <= 1'b1;
      cnt_q    <= '0;
      width_q  <= PARK_W;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      pwm_q    <= (cnt_q < {4'b0, width_q});
    end
  end

  // Sequencer: an accepted command takes priority over stepping that cycle.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    dir_d    = dir_q;
    dir_eff  = dir_q;
    nxt      = pos_q;
    if (accept) begin
      unique case (cmd_op)
        OP_PARK: begin
          target_d = PARK_W;
          state_d  = (pos_q == PARK_W) ? ST_HOLD : ST_MOVE;
        end
        OP_SWEEP: state_d = ST_SWEEP;
        OP_HOLD:  state_d = ST_HOLD;
        OP_GOTO: begin
          nxt      = goto_target(cmd_arg);
          target_d = nxt;
          state_d  = (pos_q == nxt) ? ST_HOLD : ST_MOVE;
        end
        default: state_d = state_q;
      endcase
    end else begin
      unique case (state_q)
        ST_SWEEP: begin
          // A beat reverses first; a coincident step uses the new direction.
          dir_eff = dir_q ^ beat;
          dir_d   = dir_eff;
          if (tick_step) begin
            if (dir_eff) begin
              nxt = sat_up(pos_q);
              if (nxt == MAX_W) dir_d = 1'b0;
            end else begin
              nxt = sat_down(pos_q);
              if (nxt == MIN_W) dir_d = 1'b1;
            end
            pos_d = nxt;
          end
        end
        ST_MOVE: begin
          if (tick_step) begin
            nxt   = move_toward(pos_q, target_q);
            pos_d = nxt;
            if (nxt == target_q) state_d = ST_HOLD;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // PWM frame: width is only sampled at the wrap, so frames are glitch-free.
  always_comb begin
    cnt_d   = cnt_q;
    width_d = width_q;
    if (tick_us) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d   = '0;
        width_d = pos_q;
      end else begin
        cnt_d = cnt_q + 15'd1;
      end
    end
  end

endmodule

// File: tb/tb_fan_aim_ctrl.sv
// Directed testbench for fan_aim_ctrl: reset state, PWM frame width,
// mid-frame width change, sweep stepping/clamping/beat reversal,
// GOTO move with command stall, and reset during a move.
module tb_fan_aim_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_us;
  logic        tick_step;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_arg;
  logic        cmd_ready;
  logic        beat;
  logic        pwm_out;
  logic [10:0] pos;
  logic [1:0]  state;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int hi;

  fan_aim_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick_us   (tick_us),
    .tick_step (tick_step),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_ready (cmd_ready),
    .beat      (beat),
    .pwm_out   (pwm_out),
    .pos       (pos),
    .state     (state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) begin
      tick_step = 1'b1;
      tick();
      tick_step = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; tick_us = 1'b0; tick_step = 1'b0; cmd_valid = 1'b0;
    cmd_op = 2'd0; cmd_arg = 4'd0; beat = 1'b0;
    tick();
    tick();
    check("reset_pos", pos, 1500);
    check("reset_state", state, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", cmd_ready, 1);
    check("reset_pwm", pwm_out, 0);
    rst = 1'b0;

    // Three frames; in the second, a SWEEP step at counter ~500 moves pos.
    tick_us = 1'b1;
    for (int f = 0; f < 3; f++) begin
      hi = 0;
      for (int i = 0; i < 20000; i++) begin
        if (f == 1 && i == 500) begin cmd_valid = 1'b1; cmd_op = 2'd1; end
        if (f == 1 && i == 501) begin cmd_valid = 1'b0; tick_step = 1'b1; end
        if (f == 1 && i == 502) tick_step = 1'b0;
        tick();
        if (pwm_out) hi++;
      end
      if (f == 0) check("frame1_high", hi, 1500);
      if (f == 1) check("frame2_high_old_width", hi, 1500);
      if (f == 2) check("frame3_high_new_width", hi, 1535);
    end
    tick_us = 1'b0;
    check("midframe_pos", pos, 1535);

    // Sweep up from park, clamp at max, reverse.
    do_reset();
    send_cmd(2'd1, 4'd0);
    check("sweep_state", state, 1);
    steps(1);  check("sweep_step1", pos, 1535);
    steps(1);  check("sweep_step2", pos, 1570);
    steps(12); check("sweep_step14", pos, 1990);
    steps(1);  check("sweep_clamp_max", pos, 2000);
    steps(1);  check("sweep_after_flip", pos, 1965);

    // Beat coincident with step, then beat at the lower limit.
    do_reset();
    send_cmd(2'd1, 4'd0);
    steps(2);
    check("beat_pre", pos, 1570);
    beat = 1'b1; tick_step = 1'b1; tick(); beat = 1'b0; tick_step = 1'b0;
    check("beat_step_down", pos, 1535);
    steps(16);
    check("sweep_clamp_min", pos, 1000);
    beat = 1'b1; tick_step = 1'b1; tick(); beat = 1'b0; tick_step = 1'b0;
    check("beat_at_min_stays", pos, 1000);
    steps(1);  check("beat_at_min_next", pos, 1035);

    // HOLD freezes pos; beat and tick_step are ignored.
    send_cmd(2'd2, 4'd0);
    beat = 1'b1; tick_step = 1'b1; tick(); beat = 1'b0; tick_step = 1'b0;
    steps(2);
    check("hold_state", state, 0);
    check("hold_pos", pos, 1035);

    // GOTO 15 with a PARK held pending during the move.
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_arg = 4'd15;
    tick();
    cmd_op = 2'd0;
    check("goto_state", state, 2);
    check("goto_busy", busy, 1);
    check("goto_ready", cmd_ready, 0);
    steps(13);
    check("goto_step13", pos, 1955);
    check("goto_stall_state", state, 2);
    check("goto_stall_ready", cmd_ready, 0);
    steps(1);
    check("goto_arrive_pos", pos, 1960);
    check("goto_arrive_state", state, 0);
    check("goto_arrive_busy", busy, 0);
    check("goto_arrive_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("park_accepted_state", state, 2);
    check("park_accepted_pos", pos, 1960);
    steps(2);
    check("park_move_pos", pos, 1890);

    // Reset in the middle of a move with the PWM pulse high.
    tick_us = 1'b1;
    repeat (800) tick();
    tick_us = 1'b0;
    check("premid_pwm", pwm_out, 1);
    check("premid_state", state, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pwm", pwm_out, 0);
    check("midrst_pos", pos, 1500);
    check("midrst_state", state, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
